// File: rtl/tawas_raccoon_tgt.sv
// Raccoon-space target: queues single-cycle core requests and replays them on a req/ack peripheral bus.
// Optional TAWAS_RACCOON_SWAP_EN: swaps run as read-then-write with writeback of the old value.
module tawas_raccoon_tgt #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RACCOON_CS,
    input  logic        RACCOON_SWAP,
    input  logic [2:0]  WRITEBACK_REG,
    input  logic [31:0] DADDR,
    input  logic        DWR,
    input  logic [3:0]  DMASK,
    input  logic [31:0] DOUT,
    output logic        P_REQ,
    output logic [31:0] P_ADDR,
    output logic        P_WR,
    output logic [3:0]  P_MASK,
    output logic [31:0] P_WDATA,
    input  logic        P_ACK,
    input  logic [31:0] P_RDATA,
    output logic        RC_LOAD_VLD,
    output logic [2:0]  RC_LOAD_SEL,
    output logic [31:0] RC_LOAD,
    output logic        RC_BUSY,
    output logic        RC_OVFL,
    output logic        RC_TMO,
    input  logic        RC_ERR_CLR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef struct packed {
`ifdef TAWAS_RACCOON_SWAP_EN
        logic        swap;
`endif
        logic        wr;
        logic [2:0]  sel;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

`ifdef TAWAS_RACCOON_SWAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2, SWPW = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;
`endif

    state_t state, state_n;

    entry_t mem [FIFO_DEPTH];
    entry_t din, pl;
    logic [AW:0] wptr, rptr;
    logic empty, full, push, pop, ovfl_set;

    logic [7:0]  cnt;
    logic        cnt_clr;
    logic        load_fire, tmo_set, pl_swap;
    logic [31:0] load_data, lane_data;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = (state == IDLE) && !empty;
    // Fullness is judged after this cycle's pop, so push+pop on a full queue is accepted.
    assign push     = RACCOON_CS && !(full && !pop);
    assign ovfl_set = RACCOON_CS && full && !pop;

    always_comb begin
        din       = '0;
`ifdef TAWAS_RACCOON_SWAP_EN
        din.swap  = RACCOON_SWAP;
        din.wr    = DWR;
`else
        din.wr    = DWR | RACCOON_SWAP;
`endif
        din.sel   = WRITEBACK_REG;
        din.mask  = DMASK;
        din.addr  = DADDR;
        din.wdata = DOUT;
    end

`ifdef TAWAS_RACCOON_SWAP_EN
    assign pl_swap = pl.swap;
`else
    assign pl_swap = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
            pl   <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                pl   <= mem[rptr[AW-1:0]];
            end
        end
    end

    // Lane extraction for narrow loads; unusual masks return the raw word.
    always_comb begin
        case (pl.mask)
            4'b1111: lane_data = P_RDATA;
            4'b0011: lane_data = {16'h0, P_RDATA[15:0]};
            4'b1100: lane_data = {16'h0, P_RDATA[31:16]};
            4'b0001: lane_data = {24'h0, P_RDATA[7:0]};
            4'b0010: lane_data = {24'h0, P_RDATA[15:8]};
            4'b0100: lane_data = {24'h0, P_RDATA[23:16]};
            4'b1000: lane_data = {24'h0, P_RDATA[31:24]};
            default: lane_data = P_RDATA;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        load_fire = 1'b0;
        load_data = lane_data;
        tmo_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = XFER;
                    cnt_clr = 1'b1;
                end
            end
            XFER: begin
                if (P_ACK) begin
                    if (pl_swap) begin
`ifdef TAWAS_RACCOON_SWAP_EN
                        load_fire = 1'b1;
                        state_n   = SWPW;
                        cnt_clr   = 1'b1;
`endif
                    end else if (pl.wr) begin
                        state_n = IDLE;
                    end else begin
                        load_fire = 1'b1;
                        state_n   = RESP;
                    end
                end else if (cnt == TMO_LAST) begin
                    // Abandoned loads and swaps still retire with an all-ones writeback.
                    tmo_set = 1'b1;
                    if (pl.wr && !pl_swap) begin
                        state_n = IDLE;
                    end else begin
                        load_fire = 1'b1;
                        load_data = 32'hFFFF_FFFF;
                        state_n   = RESP;
                    end
                end
            end
`ifdef TAWAS_RACCOON_SWAP_EN
            SWPW: begin
                if (P_ACK) begin
                    state_n = IDLE;
                end else if (cnt == TMO_LAST) begin
                    tmo_set = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            RC_LOAD_VLD <= 1'b0;
            RC_LOAD     <= '0;
            RC_LOAD_SEL <= '0;
            RC_OVFL     <= 1'b0;
            RC_TMO      <= 1'b0;
        end else begin
            state       <= state_n;
            RC_LOAD_VLD <= load_fire;
            if (cnt_clr)
                cnt <= '0;
            else if (P_REQ && !P_ACK)
                cnt <= cnt + 8'd1;
            if (load_fire) begin
                RC_LOAD     <= load_data;
                RC_LOAD_SEL <= pl.sel;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            if (ovfl_set)
                RC_OVFL <= 1'b1;
            else if (RC_ERR_CLR)
                RC_OVFL <= 1'b0;
            if (tmo_set)
                RC_TMO <= 1'b1;
            else if (RC_ERR_CLR)
                RC_TMO <= 1'b0;
        end
    end

`ifdef TAWAS_RACCOON_SWAP_EN
    assign P_REQ = (state == XFER) || (state == SWPW);
    assign P_WR  = ((state == XFER) && pl.wr && !pl_swap) || (state == SWPW);
`else
    assign P_REQ = (state == XFER);
    assign P_WR  = (state == XFER) && pl.wr;
`endif
    assign P_ADDR  = pl.addr;
    assign P_MASK  = pl.mask;
    assign P_WDATA = pl.wdata;
    assign RC_BUSY = !empty || (state != IDLE);

endmodule

// File: tb/tb_tawas_raccoon_tgt.sv
// Directed bench for tawas_raccoon_tgt: reads, writes, swaps, overflow, timeout and reset.
module tb_tawas_raccoon_tgt;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RACCOON_CS = 1'b0, RACCOON_SWAP = 1'b0, DWR = 1'b0;
    logic [2:0]  WRITEBACK_REG = '0;
    logic [31:0] DADDR = '0, DOUT = '0, P_RDATA = '0;
    logic [3:0]  DMASK = '0;
    logic        P_ACK = 1'b0, RC_ERR_CLR = 1'b0;
    logic        P_REQ, P_WR, RC_LOAD_VLD, RC_BUSY, RC_OVFL, RC_TMO;
    logic [31:0] P_ADDR, P_WDATA, RC_LOAD;
    logic [3:0]  P_MASK;
    logic [2:0]  RC_LOAD_SEL;

    int errs = 0;
    int nchk = 0;

    tawas_raccoon_tgt #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST), .RACCOON_CS(RACCOON_CS), .RACCOON_SWAP(RACCOON_SWAP),
        .WRITEBACK_REG(WRITEBACK_REG), .DADDR(DADDR), .DWR(DWR), .DMASK(DMASK), .DOUT(DOUT),
        .P_REQ(P_REQ), .P_ADDR(P_ADDR), .P_WR(P_WR), .P_MASK(P_MASK), .P_WDATA(P_WDATA),
        .P_ACK(P_ACK), .P_RDATA(P_RDATA), .RC_LOAD_VLD(RC_LOAD_VLD), .RC_LOAD_SEL(RC_LOAD_SEL),
        .RC_LOAD(RC_LOAD), .RC_BUSY(RC_BUSY), .RC_OVFL(RC_OVFL), .RC_TMO(RC_TMO),
        .RC_ERR_CLR(RC_ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic req(input logic swp, input logic wr, input logic [2:0] sel,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] dat);
        RACCOON_CS = 1'b1; RACCOON_SWAP = swp; DWR = wr; WRITEBACK_REG = sel;
        DADDR = addr; DMASK = mask; DOUT = dat;
        cyc();
        RACCOON_CS = 1'b0; RACCOON_SWAP = 1'b0;
    endtask

    task automatic ack(input logic [31:0] dat);
        P_ACK = 1'b1; P_RDATA = dat;
        cyc();
        P_ACK = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!P_REQ && k < 100) begin
            cyc();
            k++;
        end
        chk("req_seen", {31'd0, P_REQ}, 32'd1);
    endtask

    initial begin
        cyc();
        chk("rst_ctl", {26'd0, P_REQ, P_WR, RC_LOAD_VLD, RC_BUSY, RC_OVFL, RC_TMO}, 32'd0);
        chk("rst_addr", P_ADDR, 32'd0);
        chk("rst_load", RC_LOAD ^ P_WDATA ^ {25'd0, RC_LOAD_SEL, P_MASK}, 32'd0);
        RST = 1'b0;
        cyc();

        // Stray ack with no request outstanding
        ack(32'h1234_5678);
        chk("stray_ack_vld", {31'd0, RC_LOAD_VLD}, 32'd0);

        // Byte read, lane 2, ack three cycles after P_REQ
        req(1'b0, 1'b0, 3'd5, 32'h0100_0004, 4'b0100, 32'h0);
        chk("rd_lat_c1", {31'd0, P_REQ}, 32'd0);
        chk("rd_busy", {31'd0, RC_BUSY}, 32'd1);
        cyc();
        chk("rd_lat_c2", {31'd0, P_REQ}, 32'd1);
        chk("rd_addr", P_ADDR, 32'h0100_0004);
        chk("rd_wr", {31'd0, P_WR}, 32'd0);
        cyc(); cyc(); cyc();
        ack(32'hAABB_CCDD);
        chk("rd_vld", {31'd0, RC_LOAD_VLD}, 32'd1);
        chk("rd_data", RC_LOAD, 32'h0000_00BB);
        chk("rd_sel", {29'd0, RC_LOAD_SEL}, 32'd5);
        chk("rd_req_drop", {31'd0, P_REQ}, 32'd0);
        cyc();
        chk("rd_vld_pulse", {31'd0, RC_LOAD_VLD}, 32'd0);

        // Full-word write held until ack
        req(1'b0, 1'b1, 3'd1, 32'h0200_0000, 4'b1111, 32'h1234_5678);
        cyc();
        cyc(); cyc();
        chk("wr_req", {31'd0, P_REQ}, 32'd1);
        chk("wr_wr", {31'd0, P_WR}, 32'd1);
        chk("wr_data", P_WDATA, 32'h1234_5678);
        chk("wr_mask", {28'd0, P_MASK}, 32'hF);
        ack(32'h0);
        chk("wr_req_drop", {31'd0, P_REQ}, 32'd0);
        chk("wr_no_vld", {31'd0, RC_LOAD_VLD}, 32'd0);
        cyc();
        chk("wr_no_vld2", {31'd0, RC_LOAD_VLD}, 32'd0);

        // Swap: read old value, write back new value
        req(1'b1, 1'b1, 3'd2, 32'h0300_0008, 4'b1111, 32'h0000_0055);
        cyc();
        chk("swp_req", {31'd0, P_REQ}, 32'd1);
        chk("swp_addr", P_ADDR, 32'h0300_0008);
`ifdef TAWAS_RACCOON_SWAP_EN
        chk("swp_rd_phase", {31'd0, P_WR}, 32'd0);
        ack(32'h0000_0099);
        chk("swp_vld", {31'd0, RC_LOAD_VLD}, 32'd1);
        chk("swp_old", RC_LOAD, 32'h0000_0099);
        chk("swp_sel", {29'd0, RC_LOAD_SEL}, 32'd2);
        chk("swp_wreq", {31'd0, P_REQ}, 32'd1);
        chk("swp_wwr", {31'd0, P_WR}, 32'd1);
        chk("swp_wdata", P_WDATA, 32'h0000_0055);
        ack(32'h0);
        chk("swp_done", {31'd0, P_REQ}, 32'd0);
`else
        chk("swp_as_wr", {31'd0, P_WR}, 32'd1);
        chk("swp_wdata", P_WDATA, 32'h0000_0055);
        ack(32'h0000_0099);
        chk("swp_no_vld", {31'd0, RC_LOAD_VLD}, 32'd0);
        chk("swp_done", {31'd0, P_REQ}, 32'd0);
        cyc();
        chk("swp_no_vld2", {31'd0, RC_LOAD_VLD}, 32'd0);
`endif
        cyc(); cyc();

        // Six back-to-back strobes: first pops at once, four queue, sixth overflows
        for (int i = 0; i < 6; i++) begin
            RACCOON_CS = 1'b1; DWR = 1'b1; WRITEBACK_REG = 3'd0; DMASK = 4'hF;
            DADDR = 32'h0400_0000 + 32'(i * 4); DOUT = 32'(i);
            cyc();
        end
        RACCOON_CS = 1'b0;
        chk("ovfl_set", {31'd0, RC_OVFL}, 32'd1);
        for (int j = 0; j < 5; j++) begin
            wait_req();
            chk("ovfl_order", P_ADDR, 32'h0400_0000 + 32'(j * 4));
            chk("ovfl_wdata", P_WDATA, 32'(j));
            ack(32'h0);
        end
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                if (P_REQ) seen++;
                cyc();
            end
            chk("ovfl_dropped", 32'(seen), 32'd0);
        end
        chk("ovfl_idle", {31'd0, RC_BUSY}, 32'd0);
        RC_ERR_CLR = 1'b1;
        cyc();
        RC_ERR_CLR = 1'b0;
        chk("ovfl_clr", {31'd0, RC_OVFL}, 32'd0);

        // Timeout with ack withheld
        req(1'b0, 1'b0, 3'd3, 32'h0500_0000, 4'b0001, 32'h0);
        cyc();
        chk("tmo_req", {31'd0, P_REQ}, 32'd1);
        begin
            int k = 0;
            while (P_REQ && k < 400) begin
                cyc();
                k++;
            end
            chk("tmo_len", 32'(k), 32'd255);
        end
        chk("tmo_vld", {31'd0, RC_LOAD_VLD}, 32'd1);
        chk("tmo_data", RC_LOAD, 32'hFFFF_FFFF);
        chk("tmo_sel", {29'd0, RC_LOAD_SEL}, 32'd3);
        chk("tmo_flag", {31'd0, RC_TMO}, 32'd1);
        RC_ERR_CLR = 1'b1;
        cyc();
        RC_ERR_CLR = 1'b0;
        chk("tmo_clr", {31'd0, RC_TMO}, 32'd0);
        cyc();

        // Reset mid-transfer with two entries queued
        for (int i = 0; i < 3; i++) begin
            RACCOON_CS = 1'b1; DWR = 1'b0; DMASK = 4'hF; WRITEBACK_REG = 3'd6;
            DADDR = 32'h0600_0000 + 32'(i * 4);
            cyc();
        end
        RACCOON_CS = 1'b0;
        chk("rstx_req", {31'd0, P_REQ}, 32'd1);
        RST = 1'b1;
        #1;
        chk("rstx_req_async", {31'd0, P_REQ}, 32'd0);
        chk("rstx_ctl", {26'd0, P_REQ, P_WR, RC_LOAD_VLD, RC_BUSY, RC_OVFL, RC_TMO}, 32'd0);
        chk("rstx_addr", P_ADDR, 32'd0);
        chk("rstx_load", RC_LOAD ^ P_WDATA ^ {25'd0, RC_LOAD_SEL, P_MASK}, 32'd0);
        cyc();
        RST = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 20; k++) begin
                cyc();
                if (P_REQ || RC_BUSY) seen++;
            end
            chk("rstx_quiet", 32'(seen), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
